// File: rtl/seg7_hex_scan.sv
// Scans a 16-bit hex value onto a 4-digit common-anode 7-segment display.
// The value is snapshotted once per frame; each digit slot opens with a blanking gap.
module seg7_hex_scan #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    digit;
  logic [15:0]   snap_value;
  logic [3:0]    snap_dp;
  logic          snap_lz;

  logic [3:0]    nib;
  logic          suppress;
  logic [6:0]    glyph;
  logic          frame_edge;

  // Frame position 0 is digit 0, timer 0: the capture edge.
  assign frame_edge = (digit == 2'd0) && (timer == '0);

  // Current digit's nibble and leading-zero suppression from the snapshot.
  always_comb begin
    nib      = snap_value[3:0];
    suppress = 1'b0;
    case (digit)
      2'd0: begin
        nib      = snap_value[3:0];
        suppress = 1'b0;
      end
      2'd1: begin
        nib      = snap_value[7:4];
        suppress = snap_lz && (snap_value[15:4] == 12'h000);
      end
      2'd2: begin
        nib      = snap_value[11:8];
        suppress = snap_lz && (snap_value[15:8] == 8'h00);
      end
      default: begin
        nib      = snap_value[15:12];
        suppress = snap_lz && (snap_value[15:12] == 4'h0);
      end
    endcase
  end

  // Hex to active-low segments, bit order g..a.
  always_comb begin
    glyph = 7'b1111111;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  end

  // Slot FSM, slot timer, digit index, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      timer       <= '0;
      digit       <= 2'd0;
      snap_value  <= 16'h0000;
      snap_dp     <= 4'h0;
      snap_lz     <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (frame_edge) begin
        snap_value <= value;
        snap_dp    <= dp_in;
        snap_lz    <= lz_en;
      end

      case (state)
        BLANK: begin
          an  <= 4'b1111;
          seg <= 7'b1111111;
          dp  <= 1'b1;
          if (timer == BLANK_LAST) state <= SHOW;
        end
        default: begin
          an  <= ~(4'b0001 << digit);
          seg <= suppress ? 7'b1111111 : glyph;
          dp  <= suppress | ~snap_dp[digit];
          if (timer == TIMER_LAST) state <= BLANK;
        end
      endcase

      if (timer == TIMER_LAST) begin
        timer <= '0;
        digit <= digit + 2'd1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
